crc_code_checker: RTL

Read-path counterpart of the CRC write controller: on a read request it fetches one stored codeword (DATA_W data bits plus CRC_W CRC bits) from memory, shifts it serially through a CRC-4 remainder register, and returns the data field with a pass/fail flag. It sits between the memory read port and the consumer of read data. It recomputes the remainder over the full codeword and flags any non-zero syndrome.

---
 rtl/crc_code_checker.sv | 102 ++++++++++
 1 files changed

// File: rtl/crc_code_checker.sv
// Read-path CRC checker: fetches one {data, crc} codeword and clocks it serially through a CRC remainder register.
// Optional failed-read counter is built only when CRC_CHK_ERR_COUNT_EN is defined; otherwise err_count is tied to 0.
module crc_code_checker #(
  parameter int                DATA_W = 8,
  parameter int                CRC_W  = 4,
  parameter logic [CRC_W-1:0]  POLY   = 4'b0011
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     read,
  input  logic [DATA_W+CRC_W-1:0]  mem_rdata,
  output logic                     read_mem_en,
  output logic                     read_mem_busy,
  output logic [DATA_W-1:0]        data_out,
  output logic                     data_valid,
  output logic                     crc_error,
  output logic [7:0]               err_count
);

  localparam int N     = DATA_W + CRC_W;
  localparam int CNT_W = $clog2(N + 1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, SHIFT, DONE} state_t;

  state_t             state_reg;
  logic [N-1:0]       shift_reg;
  logic [CRC_W-1:0]   rem_reg;
  logic [CRC_W-1:0]   rem_next;
  logic [CNT_W-1:0]   cnt_reg;
  logic [DATA_W-1:0]  data_reg;
  logic [DATA_W-1:0]  data_out_reg;
  logic               crc_error_reg;
  logic               fb;
  logic               last_shift;

  assign fb         = rem_reg[CRC_W-1] ^ shift_reg[N-1];
  assign rem_next   = {rem_reg[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
  assign last_shift = (cnt_reg == CNT_W'(N - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      rem_reg       <= '0;
      cnt_reg       <= '0;
      data_reg      <= '0;
      data_out_reg  <= '0;
      crc_error_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE:  if (read) state_reg <= FETCH;
        FETCH: state_reg <= LOAD;
        LOAD: begin
          shift_reg <= mem_rdata;
          data_reg  <= mem_rdata[N-1:CRC_W];
          rem_reg   <= '0;
          cnt_reg   <= '0;
          state_reg <= SHIFT;
        end
        SHIFT: begin
          rem_reg   <= rem_next;
          shift_reg <= {shift_reg[N-2:0], 1'b0};
          cnt_reg   <= cnt_reg + 1'b1;
          // The final shift's remainder is judged directly so the result lands on the DONE entry edge.
          if (last_shift) begin
            data_out_reg  <= data_reg;
            crc_error_reg <= (rem_next != '0);
            state_reg     <= DONE;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign read_mem_en   = (state_reg == FETCH);
  assign read_mem_busy = (state_reg == FETCH) || (state_reg == LOAD) || (state_reg == SHIFT);
  assign data_valid    = (state_reg == DONE);
  assign data_out      = data_out_reg;
  assign crc_error     = crc_error_reg;

`ifdef CRC_CHK_ERR_COUNT_EN
  logic [7:0] err_count_reg;
  logic       done_fail;

  assign done_fail = (state_reg == SHIFT) && last_shift && (rem_next != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count_reg <= '0;
    end else if (done_fail && (err_count_reg != 8'hFF)) begin
      err_count_reg <= err_count_reg + 8'd1;
    end
  end

  assign err_count = err_count_reg;
`else
  assign err_count = '0;
`endif

endmodule
